// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency-meter datapath.
package freq_meter_pkg;

    // Width of the gate-range selector (four ranges).
    localparam int RANGE_W = 2;

    // Default gate lengths in control-clock cycles; also used by display scaling.
    localparam int unsigned GATE_TICKS_DEF_0 = 32'd50_000;
    localparam int unsigned GATE_TICKS_DEF_1 = 32'd500_000;
    localparam int unsigned GATE_TICKS_DEF_2 = 32'd5_000_000;
    localparam int unsigned GATE_TICKS_DEF_3 = 32'd50_000_000;

    // Measurement sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_GATE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4
    } fgs_state_e;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter shared by the gate and settle phases; done while at zero.
module gate_timer #(
    parameter int unsigned TICK_W = 32'd27
) (
    input  logic              clk_ctrl,
    input  logic              reset_n,
    input  logic              load,
    input  logic [TICK_W-1:0] load_val,
    output logic              done
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    // Next count: a load wins, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {TICK_W{1'b0}}) begin
            cnt_d = cnt_q - TICK_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_ctrl or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {TICK_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == {TICK_W{1'b0}});

endmodule

// File: rtl/freq_gate_sequencer.sv
// Restartable gate/settle/latch sequencer with optional auto-ranging.
module freq_gate_sequencer
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_TICKS_0 = GATE_TICKS_DEF_0,
    parameter int unsigned GATE_TICKS_1 = GATE_TICKS_DEF_1,
    parameter int unsigned GATE_TICKS_2 = GATE_TICKS_DEF_2,
    parameter int unsigned GATE_TICKS_3 = GATE_TICKS_DEF_3,
    parameter int unsigned SETTLE_CYC   = 32'd2,
    parameter int unsigned TICK_W       = 32'd27
) (
    input  logic               clk_ctrl,
    input  logic               reset_n,
    input  logic               run,
    input  logic               auto_en,
    input  logic [RANGE_W-1:0] range_sel,
    input  logic               ovf,
    input  logic               count_low,
    output logic               enable,
    output logic               cnt_clr_n,
    output logic               lock,
    output logic               meas_valid,
    output logic               over_range,
    output logic [RANGE_W-1:0] range_out
);

    localparam logic [RANGE_W-1:0] RANGE_MIN = {RANGE_W{1'b0}};
    localparam logic [RANGE_W-1:0] RANGE_MAX = {RANGE_W{1'b1}};
    localparam logic [TICK_W-1:0]  SETTLE_LAST = TICK_W'(SETTLE_CYC - 32'd1);

    // Timer reload value for a gate on the given range (length minus one).
    function automatic logic [TICK_W-1:0] gate_last_f(input logic [RANGE_W-1:0] rng);
        case (rng)
            2'd0:    gate_last_f = TICK_W'(GATE_TICKS_0 - 32'd1);
            2'd1:    gate_last_f = TICK_W'(GATE_TICKS_1 - 32'd1);
            2'd2:    gate_last_f = TICK_W'(GATE_TICKS_2 - 32'd1);
            default: gate_last_f = TICK_W'(GATE_TICKS_3 - 32'd1);
        endcase
    endfunction

    fgs_state_e         state_q, state_d;
    logic               ovf_seen_q, ovf_seen_d;
    logic [RANGE_W-1:0] range_q, range_d;
    logic [RANGE_W-1:0] auto_rng_q, auto_rng_d;
    logic               enable_q, enable_d;
    logic               cnt_clr_n_q, cnt_clr_n_d;
    logic               lock_q, lock_d;
    logic               meas_valid_q, meas_valid_d;
    logic               over_range_q, over_range_d;
    logic [RANGE_W-1:0] sel_rng_s;
    logic               retry_s;
    logic               tmr_load_s;
    logic [TICK_W-1:0]  tmr_val_s;
    logic               tmr_done_s;

    gate_timer #(
        .TICK_W (TICK_W)
    ) u_gate_timer (
        .clk_ctrl (clk_ctrl),
        .reset_n  (reset_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .done     (tmr_done_s)
    );

    // Next state, range bookkeeping and registered-output targets.
    // Outputs are derived from the next state so each one is high exactly
    // while the FSM sits in the matching state. The retry decision is made
    // on entry to LATCH, so in LATCH a low lock_q means "retry".
    always_comb begin
        state_d      = state_q;
        ovf_seen_d   = ovf_seen_q;
        range_d      = range_q;
        auto_rng_d   = auto_rng_q;
        over_range_d = over_range_q;
        lock_d       = 1'b0;
        retry_s      = 1'b0;
        tmr_load_s   = 1'b0;
        tmr_val_s    = {TICK_W{1'b0}};
        sel_rng_s    = auto_en ? auto_rng_q : range_sel;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                range_d    = sel_rng_s;
                ovf_seen_d = 1'b0;
                tmr_load_s = 1'b1;
                tmr_val_s  = gate_last_f(sel_rng_s);
                state_d    = ST_GATE;
            end
            ST_GATE: begin
                ovf_seen_d = ovf_seen_q | ovf;
                if (tmr_done_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SETTLE_LAST;
                    state_d    = ST_SETTLE;
                end else begin
                    state_d = ST_GATE;
                end
            end
            ST_SETTLE: begin
                ovf_seen_d = ovf_seen_q | ovf;
                if (tmr_done_s) begin
                    retry_s = auto_en & ovf_seen_d & (range_q != RANGE_MIN);
                    lock_d  = ~retry_s;
                    if (retry_s) begin
                        over_range_d = over_range_q;
                    end else begin
                        over_range_d = ovf_seen_d;
                    end
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_LATCH: begin
                if (auto_en) begin
                    if (!lock_q && (range_q != RANGE_MIN)) begin
                        range_d = range_q - RANGE_W'(1'b1);
                    end else if (!ovf_seen_q && count_low && (range_q != RANGE_MAX)) begin
                        range_d = range_q + RANGE_W'(1'b1);
                    end else begin
                        range_d = range_q;
                    end
                    auto_rng_d = range_d;
                end else begin
                    range_d    = range_q;
                    auto_rng_d = auto_rng_q;
                end
                if (run) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        enable_d     = (state_d == ST_GATE);
        cnt_clr_n_d  = (state_d != ST_CLEAR);
        meas_valid_d = lock_d;
    end

    // State, range and output registers.
    always_ff @(posedge clk_ctrl or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ovf_seen_q   <= 1'b0;
            range_q      <= RANGE_MIN;
            auto_rng_q   <= RANGE_MIN;
            enable_q     <= 1'b0;
            cnt_clr_n_q  <= 1'b0;
            lock_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            over_range_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ovf_seen_q   <= ovf_seen_d;
            range_q      <= range_d;
            auto_rng_q   <= auto_rng_d;
            enable_q     <= enable_d;
            cnt_clr_n_q  <= cnt_clr_n_d;
            lock_q       <= lock_d;
            meas_valid_q <= meas_valid_d;
            over_range_q <= over_range_d;
        end
    end

    assign enable     = enable_q;
    assign cnt_clr_n  = cnt_clr_n_q;
    assign lock       = lock_q;
    assign meas_valid = meas_valid_q;
    assign over_range = over_range_q;
    assign range_out  = range_q;

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// Randomized bench for freq_gate_sequencer against a per-measurement reference model.
module tb_freq_gate_sequencer;
    import freq_meter_pkg::*;

    localparam int S_CYC = 2;

    logic       clk_ctrl = 1'b0;
    logic       reset_n;
    logic       run;
    logic       auto_en;
    logic [1:0] range_sel;
    logic       ovf;
    logic       count_low;
    logic       enable;
    logic       cnt_clr_n;
    logic       lock;
    logic       meas_valid;
    logic       over_range;
    logic [1:0] range_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: retained auto range, visible range, over-range flag.
    int m_auto = 0;
    int m_rng  = 0;
    int m_ovr  = 0;

    freq_gate_sequencer #(
        .GATE_TICKS_0 (32'd4),
        .GATE_TICKS_1 (32'd8),
        .GATE_TICKS_2 (32'd16),
        .GATE_TICKS_3 (32'd32),
        .SETTLE_CYC   (32'd2),
        .TICK_W       (32'd8)
    ) dut (
        .clk_ctrl   (clk_ctrl),
        .reset_n    (reset_n),
        .run        (run),
        .auto_en    (auto_en),
        .range_sel  (range_sel),
        .ovf        (ovf),
        .count_low  (count_low),
        .enable     (enable),
        .cnt_clr_n  (cnt_clr_n),
        .lock       (lock),
        .meas_valid (meas_valid),
        .over_range (over_range),
        .range_out  (range_out)
    );

    // Control clock.
    always #5 clk_ctrl = ~clk_ctrl;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input int en, input int clrn, input int lk, input int mv,
                                          input int ovr, input int rng);
        logic [31:0] v;
        v = 32'd0;
        v[6] = en[0];
        v[5] = clrn[0];
        v[4] = lk[0];
        v[3] = mv[0];
        v[2] = ovr[0];
        v[1:0] = rng[1:0];
        return v;
    endfunction

    function automatic logic [31:0] outs();
        return {25'd0, enable, cnt_clr_n, lock, meas_valid, over_range, range_out};
    endfunction

    function automatic int ticks(input int r);
        case (r)
            0:       return 4;
            1:       return 8;
            2:       return 16;
            default: return 32;
        endcase
    endfunction

    // One active edge, then compare all outputs on the falling edge.
    task automatic clk_and_check(input string tag, input logic [31:0] exp);
        @(posedge clk_ctrl);
        @(negedge clk_ctrl);
        check_val(tag, outs(), exp);
    endtask

    // IDLE cycles; caller has already driven run low for the first edge.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            clk_and_check("idle", pack(0, 1, 0, 0, m_ovr, m_rng));
            run       = 1'b0;
            ovf       = 1'($urandom_range(0, 1));
            count_low = 1'($urandom_range(0, 1));
            range_sel = 2'($urandom_range(0, 3));
            auto_en   = 1'($urandom_range(0, 1));
        end
    endtask

    // One full measurement from the edge into CLEAR up to driving the LATCH-cycle inputs.
    // ovf_mode: 0 none, 1 single pulse mid-gate, 2 sparse random.
    task automatic meas(input bit auto_v, input int sel_v, input bit run_after, input bit cl,
                        input int ovf_mode);
        int  r;
        int  n;
        int  nr;
        bit  seen;
        bit  ov;
        bit  lk;
        r    = auto_v ? m_auto : sel_v;
        n    = ticks(r);
        seen = 1'b0;

        clk_and_check("clear", pack(0, 0, 0, 0, m_ovr, m_rng));
        auto_en   = auto_v;
        range_sel = 2'(sel_v);
        ovf       = 1'($urandom_range(0, 1));
        run       = 1'($urandom_range(0, 1));
        count_low = 1'($urandom_range(0, 1));

        for (int i = 0; i < n + S_CYC; i++) begin
            if (i < n) begin
                clk_and_check("gate", pack(1, 1, 0, 0, m_ovr, r));
            end else begin
                clk_and_check("settle", pack(0, 1, 0, 0, m_ovr, r));
            end
            ov = (ovf_mode == 1 && i == n / 2) || (ovf_mode == 2 && $urandom_range(0, 31) == 0);
            seen      = seen | ov;
            ovf       = ov;
            range_sel = 2'($urandom_range(0, 3));
            run       = 1'($urandom_range(0, 1));
            count_low = 1'($urandom_range(0, 1));
        end

        lk = !(auto_v && seen && r > 0);
        if (!lk) nr = r - 1;
        else if (auto_v && !seen && cl && r < 3) nr = r + 1;
        else nr = r;
        if (lk) m_ovr = seen;

        clk_and_check("latch", pack(0, 1, lk, lk, m_ovr, r));
        run       = run_after;
        count_low = cl;
        ovf       = 1'($urandom_range(0, 1));
        range_sel = 2'($urandom_range(0, 3));

        m_rng = nr;
        if (auto_v) m_auto = nr;
    endtask

    initial begin
        reset_n   = 1'b0;
        run       = 1'b0;
        auto_en   = 1'b0;
        range_sel = 2'd0;
        ovf       = 1'b0;
        count_low = 1'b0;
        #22;
        check_val("reset_vals", outs(), pack(0, 0, 0, 0, 0, 0));
        @(negedge clk_ctrl);
        reset_n = 1'b1;
        clk_and_check("rst_release", pack(0, 1, 0, 0, 0, 0));
        idle_cycles(2);

        // Manual range 1, run pulsed once.
        run = 1'b1;
        meas(1'b0, 1, 1'b0, 1'b0, 0);
        idle_cycles(3);

        // Continuous run on range 0.
        run = 1'b1;
        meas(1'b0, 0, 1'b1, 1'b0, 0);
        meas(1'b0, 0, 1'b1, 1'b0, 2);
        meas(1'b0, 0, 1'b0, 1'b0, 0);
        idle_cycles(2);

        // Auto up-range with saturation at 3.
        run = 1'b1;
        for (int k = 0; k < 5; k++) meas(1'b1, 0, (k < 4), 1'b1, 0);
        idle_cycles(2);

        // Manual mode ignores count_low.
        run = 1'b1;
        meas(1'b0, 0, 1'b1, 1'b1, 0);
        meas(1'b0, 0, 1'b0, 1'b1, 0);
        idle_cycles(2);

        // Overflow down-ranging to 0, then overflow on the shortest range.
        run = 1'b1;
        meas(1'b1, 0, 1'b1, 1'b0, 1);
        meas(1'b1, 0, 1'b1, 1'b0, 1);
        meas(1'b1, 0, 1'b1, 1'b0, 0);
        meas(1'b1, 0, 1'b1, 1'b0, 1);
        meas(1'b1, 0, 1'b0, 1'b0, 1);
        idle_cycles(2);

        // Asynchronous reset during gate cycle 5 of a range-1 measurement.
        run = 1'b1;
        clk_and_check("clear_pre_rst", pack(0, 0, 0, 0, m_ovr, m_rng));
        auto_en   = 1'b0;
        range_sel = 2'd1;
        run       = 1'b0;
        ovf       = 1'b0;
        for (int i = 0; i < 4; i++) clk_and_check("gate_pre_rst", pack(1, 1, 0, 0, m_ovr, 1));
        @(posedge clk_ctrl);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_async", outs(), pack(0, 0, 0, 0, 0, 0));
        m_auto = 0;
        m_rng  = 0;
        m_ovr  = 0;
        @(negedge clk_ctrl);
        reset_n = 1'b1;
        clk_and_check("rst_midgate_release", pack(0, 1, 0, 0, 0, 0));
        idle_cycles(1);

        // Randomized measurements with random run drops and idle gaps.
        run = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bit ra;
            ra = 1'($urandom_range(0, 1));
            meas(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), ra,
                 1'($urandom_range(0, 1)), 2);
            if (!ra) begin
                idle_cycles(int'($urandom_range(1, 3)));
                run = 1'b1;
            end
        end
        run = 1'b0;
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/freq_gate_sequencer.md
# freq_gate_sequencer

Measurement sequencer for the frequency-meter datapath, running on the control clock. It drives the counter bank's gate (`enable`), the active-low counter clear and the display latch strobe (`lock`). Gate length is selectable from four ranges, with optional auto-ranging from the counter's overflow and low-count flags. It replaces the fixed three-phase control pattern with a parameterised, restartable FSM.

## Interface
- `GATE_TICKS_0`, default 50_000: gate length in `clk_ctrl` cycles for range 0, the shortest gate.
- `GATE_TICKS_1`, default 500_000: gate length for range 1.
- `GATE_TICKS_2`, default 5_000_000: gate length for range 2.
- `GATE_TICKS_3`, default 50_000_000: gate length for range 3, the longest gate.
- `SETTLE_CYC`, default 2: idle cycles between gate close and latch, for counter synchroniser drain; legal range 1..15.
- `TICK_W`, default 27: tick counter width; must hold `max(GATE_TICKS_*)-1`.

Ports:
- `clk_ctrl  in  1`: control clock; everything is in this single domain.
- `reset_n  in  1`: asynchronous, active-low reset.
- `run  in  1`: level; while high, measurements repeat back-to-back.
- `auto_en  in  1`: 1 = auto-range; 0 = use `range_sel`.
- `range_sel  in  2`: manual range, sampled only in CLEAR.
- `ovf  in  1`: counter-bank overflow; may pulse anytime during GATE.
- `count_low  in  1`: counter-bank flag meaning the most-significant digit is zero; sampled only in LATCH.
- `enable  out  1`: counter gate.
- `cnt_clr_n  out  1`: active-low counter clear.
- `lock  out  1`: display latch strobe.
- `meas_valid  out  1`: one-cycle pulse; a result was latched.
- `over_range  out  1`: the latched result overflowed on the shortest range.
- `range_out  out  2`: range used by the measurement in progress or last latched.

## Operation
- FSM states are IDLE, CLEAR, GATE, SETTLE, LATCH. All outputs are registered and asserted exactly in the cycles the FSM spends in the corresponding state.
- **IDLE**: `enable`=0, `cnt_clr_n`=1, `lock`=0. Moves to CLEAR on the edge where `run`=1.
- **CLEAR**: lasts 1 cycle.
  - `cnt_clr_n`=0.
  - Range is set: `range_sel` if `auto_en`=0, otherwise the retained auto range.
  - The tick counter is loaded with `GATE_TICKS_r - 1` and sticky `ovf_seen` is cleared.
  - Moves to GATE.
- **GATE**: `enable`=1 for exactly `GATE_TICKS_r` cycles. `ovf_seen` is set on any cycle where `ovf`=1. Moves to SETTLE.
- **SETTLE**: lasts `SETTLE_CYC` cycles with `enable`=0. `ovf` is still OR-ed into `ovf_seen`. Moves to LATCH.
- **LATCH**: lasts 1 cycle.
  - Retry case, when `auto_en`=1, `ovf_seen`=1 and range>0: `lock`=0, `meas_valid`=0, and range decrements by 1.
  - Otherwise: `lock`=1 and `meas_valid`=1, and `over_range` is loaded with `ovf_seen`.
  - Up-range case, when `auto_en`=1, `ovf_seen`=0, `count_low`=1 and range<3: range increments by 1 after the latch.
  - Moves to CLEAR if `run`=1, otherwise to IDLE.
- Range saturates at 0 and 3 in both directions; it never wraps.
- Dropping `run` mid-measurement does not abort: the current measurement completes through LATCH, then the FSM goes to IDLE.
- `range_sel` and `auto_en` changes outside CLEAR take effect at the next CLEAR. `auto_en` is also read in LATCH.
- Reset values, applied asynchronously at any point including mid-gate:
  - state = IDLE
  - `enable`=0, `cnt_clr_n`=0, `lock`=0, `meas_valid`=0
  - `over_range`=0, `range_out`=0, auto range=0
- After reset release, `cnt_clr_n` returns to 1 on the first clock edge.

## Timing
- Measurement period is `GATE_TICKS_r + SETTLE_CYC + 2` cycles.
- From `run` sampled high in IDLE to `lock` high: `GATE_TICKS_r + SETTLE_CYC + 2` edges.
- `lock` and `meas_valid` are coincident single-cycle pulses.
- `enable` never overlaps `cnt_clr_n`=0 or `lock`=1.
- `range_out` updates on the edge leaving LATCH or CLEAR. It is stable throughout GATE.

## Structure
- Shared package `freq_meter_pkg` holds:
  - the state enum
  - the `RANGE_W`=2 constant
  - the default gate-tick constants, also reused by the display scaling logic
- One sub-module, `gate_timer`: a loadable `TICK_W`-bit down-counter with a `load` input and a `done` output (count==0). It is shared by GATE and SETTLE.
- The range register and the `ovf_seen` register live in the top module.

## Test plan
All scenarios use the overrides `GATE_TICKS`=4/8/16/32 and `SETTLE_CYC`=2.
- **Manual range, single measurement:** `auto_en`=0, `range_sel`=1, `run` pulsed for 1 cycle -> CLEAR 1 cycle, `enable` high exactly 8 cycles, `lock` and `meas_valid` at edge 12, then IDLE.
- **Continuous run:** `run` held, range 0 -> `lock` every 8 cycles; `cnt_clr_n` low on the cycle after each `lock`.
- **Overflow down-range:** `auto_en`=1, auto range driven to 2, `ovf` pulsed mid-gate -> no `lock`, `range_out`=1, next gate lasts 8 cycles.
- **Overflow at range 0:** `auto_en`=1 at range 0 with `ovf` -> `lock`=1 and `over_range`=1.
- **Up-range with saturation:**
  - `count_low`=1 held in LATCH -> range steps 0→1→2→3, then stays at 3.
  - Same sequence with `auto_en`=0 -> range does not change.
- **Reset and run-drop:**
  - `reset_n` low in GATE cycle 5 -> `enable`=0 and `cnt_clr_n`=0 immediately, without waiting for a clock.
  - After release: IDLE, `range_out`=0.
  - `run` dropped mid-gate -> the measurement still latches, then the FSM goes to IDLE.
